// File: rtl/mpe_pkg.sv
// Shared types and latency helpers for the MPE column controller.
package mpe_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} ctrl_state_t;

  localparam int NUMBER_PE_DFLT  = 9;
  localparam int PE_LATENCY_DFLT = 1;

  // Cycles from PE0 capture to the last PE's psum update.
  function automatic int skew_depth(input int npe, input int lat);
    return npe * lat;
  endfunction

  localparam int SKEW_DEPTH = skew_depth(NUMBER_PE_DFLT, PE_LATENCY_DFLT);
  localparam int TOTAL_LAT  = skew_depth(NUMBER_PE_DFLT, PE_LATENCY_DFLT);

endpackage

// File: rtl/mpe_skew_line.sv
// Token shift register plus per-word data skew; word k reaches its tap k*PE_LATENCY
// cycles after PE0, and each tap holds its last value between tokens.
module mpe_skew_line
  import mpe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUMBER_PE  = 9,
  parameter int PE_LATENCY = 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rest_n,
  input  logic                                 vld_i,
  input  logic [NUMBER_PE-1:0][DATA_WIDTH-1:0] data_i,
  output logic [NUMBER_PE-1:0]                 left_tap_o,
  output logic [NUMBER_PE-1:0]                 right_tap_o,
  output logic                                 last_tap_o,
  output logic [NUMBER_PE-1:0][DATA_WIDTH-1:0] data_tap_o
);

  localparam int STAGES = skew_depth(NUMBER_PE, PE_LATENCY) + 1;

  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;

  assign vld_pipe   = {vld_q, vld_i};
  assign last_tap_o = vld_pipe[STAGES];

  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) vld_q <= '0;
    else           vld_q <= vld_pipe[STAGES-1:0];
  end

  for (genvar k = 0; k < NUMBER_PE; k++) begin : g_lane
    localparam int D = 1 + k * PE_LATENCY;
    logic [D:1][DATA_WIDTH-1:0] d_q;
    logic [DATA_WIDTH-1:0]      din;

    assign din            = data_i[k];
    assign left_tap_o[k]  = vld_pipe[D];
    assign right_tap_o[k] = vld_pipe[D+1];
    assign data_tap_o[k]  = d_q[D];

    // Stages only load behind a token, so gaps never disturb held words.
    always_ff @(posedge i_clk or negedge i_rest_n) begin
      if (!i_rest_n) d_q <= '0;
      else begin
        if (vld_pipe[0]) d_q[1] <= din;
        for (int j = 2; j <= D; j++)
          if (vld_pipe[j-1]) d_q[j] <= d_q[j-1];
      end
    end
  end

endmodule

// File: rtl/mpe_col_ctrl.sv
// Column sequencer: one weight load per job, then streams fmap vectors through the skew line.
module mpe_col_ctrl
  import mpe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUMBER_PE  = 9,
  parameter int PE_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rest_n,
  input  logic                            start,
  input  logic [CNT_W-1:0]                num_vec,
  output logic                            busy,
  output logic                            done,
  input  logic                            w_valid,
  output logic                            w_ready,
  output logic                            weight_en,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUMBER_PE*DATA_WIDTH-1:0] in_fmap,
  output logic [NUMBER_PE-1:0]            i_left_en,
  output logic [NUMBER_PE-1:0]            i_right_en,
  output logic [NUMBER_PE*DATA_WIDTH-1:0] o_fmap,
  output logic                            out_valid,
  output logic [CNT_W-1:0]                out_idx
);

  ctrl_state_t      state_q;
  logic [CNT_W-1:0] nvec_q, iss_q, idx_q;
  logic             busy_q, done_q, w_ready_q, weight_en_q, in_ready_q;
  logic             accept;

  assign accept    = in_valid && in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign w_ready   = w_ready_q;
  assign weight_en = weight_en_q;
  assign in_ready  = in_ready_q;
  assign out_idx   = idx_q;

  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      state_q     <= IDLE;
      nvec_q      <= '0;
      iss_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_ready_q   <= 1'b0;
      weight_en_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      weight_en_q <= 1'b0;
      done_q      <= 1'b0;
      if (accept)    iss_q <= iss_q + CNT_W'(1);
      if (out_valid) idx_q <= idx_q + CNT_W'(1);
      case (state_q)
        IDLE: if (start) begin
          if (num_vec != '0) begin
            nvec_q    <= num_vec;
            iss_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            w_ready_q <= 1'b1;
            state_q   <= LOAD_W;
          end else begin
            done_q <= 1'b1;
          end
        end
        LOAD_W: if (w_valid) begin
          w_ready_q   <= 1'b0;
          weight_en_q <= 1'b1;
          in_ready_q  <= 1'b1;
          state_q     <= STREAM;
        end
        STREAM: if (accept && (iss_q + CNT_W'(1)) == nvec_q) begin
          in_ready_q <= 1'b0;
          state_q    <= DRAIN;
        end
        // idx_q reaches nvec_q only after the final out_valid edge, so done always trails it.
        DRAIN: if (idx_q == nvec_q) begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mpe_skew_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUMBER_PE  (NUMBER_PE),
    .PE_LATENCY (PE_LATENCY)
  ) u_skew (
    .i_clk       (i_clk),
    .i_rest_n    (i_rest_n),
    .vld_i       (accept),
    .data_i      (in_fmap),
    .left_tap_o  (i_left_en),
    .right_tap_o (i_right_en),
    .last_tap_o  (out_valid),
    .data_tap_o  (o_fmap)
  );

endmodule

// File: tb/tb_mpe_col_ctrl.sv
// Self-checking bench: cycle-accurate accept-history model plus out_idx scoreboard.
module tb_mpe_col_ctrl;
  localparam int DW = 32, NPE = 9, CW = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start = 0, w_valid = 0, in_valid = 0;
  logic [CW-1:0]     num_vec = '0;
  logic [NPE*DW-1:0] in_fmap = '0;
  logic              busy, done, w_ready, weight_en, in_ready, out_valid;
  logic [NPE-1:0]    left_en, right_en;
  logic [NPE*DW-1:0] o_fmap;
  logic [CW-1:0]     out_idx;

  logic              start2 = 0, w_valid2 = 0, in_valid2 = 0;
  logic [CW-1:0]     num_vec2 = '0;
  logic [NPE*DW-1:0] in_fmap2 = '0;
  logic              busy2, done2, w_ready2, weight_en2, in_ready2, out_valid2;
  logic [NPE-1:0]    left_en2, right_en2;
  logic [NPE*DW-1:0] o_fmap2;
  logic [CW-1:0]     out_idx2;

  mpe_col_ctrl #(.DATA_WIDTH(DW), .NUMBER_PE(NPE), .PE_LATENCY(1), .CNT_W(CW)) u_dut (
    .i_clk(clk), .i_rest_n(rst_n), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .weight_en(weight_en), .in_valid(in_valid),
    .in_ready(in_ready), .in_fmap(in_fmap), .i_left_en(left_en), .i_right_en(right_en),
    .o_fmap(o_fmap), .out_valid(out_valid), .out_idx(out_idx));

  mpe_col_ctrl #(.DATA_WIDTH(DW), .NUMBER_PE(NPE), .PE_LATENCY(2), .CNT_W(CW)) u_dut2 (
    .i_clk(clk), .i_rest_n(rst_n), .start(start2), .num_vec(num_vec2), .busy(busy2), .done(done2),
    .w_valid(w_valid2), .w_ready(w_ready2), .weight_en(weight_en2), .in_valid(in_valid2),
    .in_ready(in_ready2), .in_fmap(in_fmap2), .i_left_en(left_en2), .i_right_en(right_en2),
    .o_fmap(o_fmap2), .out_valid(out_valid2), .out_idx(out_idx2));

  int ntests = 0, nfail = 0, cyc = 0, job_idx = 0;
  int sbq[$];

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  // ah[j] = accept seen j+1 cycles ago; fh[j] = fmap accepted then
  logic [31:0]       ah;
  logic [NPE*DW-1:0] fh [0:15];
  logic [NPE*DW-1:0] exp_fmap;
  logic [NPE-1:0]    el, er;

  always @(negedge clk) begin
    if (!rst_n) begin
      ah = '0; exp_fmap = '0; sbq.delete();
      for (int j = 0; j < 16; j++) fh[j] = '0;
    end else begin
      for (int k = 0; k < NPE; k++) begin
        el[k] = ah[k];
        er[k] = ah[k+1];
        if (ah[k]) exp_fmap[k*DW +: DW] = fh[k][k*DW +: DW];
      end
      ntests++;
      if (left_en !== el || right_en !== er || out_valid !== ah[NPE]) begin
        nfail++;
        $display("FAIL strobes cyc=%0d: left=%b right=%b ov=%b, required left=%b right=%b ov=%b",
                 cyc, left_en, right_en, out_valid, el, er, ah[NPE]);
      end
      ntests++;
      if (o_fmap !== exp_fmap) begin
        nfail++;
        $display("FAIL o_fmap cyc=%0d: got %h required %h", cyc, o_fmap, exp_fmap);
      end
      if (out_valid === 1'b1) begin
        ntests++;
        if (sbq.size() == 0) begin
          nfail++;
          $display("FAIL out_valid_unexpected cyc=%0d: out_idx=%0d, required no result", cyc, out_idx);
        end else begin
          int e;
          e = sbq.pop_front();
          if (out_idx !== CW'(e)) begin
            nfail++;
            $display("FAIL out_idx cyc=%0d: got %0d required %0d", cyc, out_idx, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back(job_idx);
        job_idx++;
      end
      for (int j = 15; j > 0; j--) fh[j] = fh[j-1];
      fh[0] = in_fmap;
      ah = {ah[30:0], in_valid && in_ready};
    end
  end

  int r_wen, r_wr, r_ir, r_ov, r_done, r_bsyseen, r_busy;
  int first_acc, first_ov, last_ov, done_cyc, start_cyc;
  logic [31:0] ov_bits;

  task automatic do_job(input int nv, input logic [31:0] pat, input int plen, input bit rnd);
    int pi;
    bit wsent;
    r_wen = 0; r_wr = 0; r_ir = 0; r_ov = 0; r_done = 0; r_bsyseen = 0;
    first_acc = -1; first_ov = -1; last_ov = -1; done_cyc = -1; ov_bits = '0;
    pi = 0; wsent = 0;
    job_idx = 0; num_vec = CW'(nv); start = 1; start_cyc = cyc;
    tick();
    start = 0;
    for (int i = 0; i < 400; i++) begin
      if (weight_en) r_wen++;
      if (w_ready) r_wr++;
      if (in_ready) r_ir++;
      if (busy) r_bsyseen++;
      if (out_valid) begin
        r_ov++;
        if (first_ov < 0) first_ov = cyc;
        last_ov = cyc;
      end
      if (first_ov >= 0 && cyc - first_ov < 32) ov_bits[cyc - first_ov] = out_valid;
      if (done) begin r_done++; done_cyc = cyc; end
      w_valid = w_ready && !wsent;
      if (w_valid) wsent = 1;
      in_valid = 0;
      if (in_ready) begin
        in_valid = (pi < plen) ? pat[pi] : 1'b1;
        pi++;
        if (in_valid) begin
          if (first_acc < 0) first_acc = cyc;
          for (int k = 0; k < NPE; k++) in_fmap[k*DW +: DW] = rnd ? $urandom : DW'(k + 1);
        end
      end
      if (done_cyc >= 0 && cyc - done_cyc >= 3) break;
      tick();
    end
    in_valid = 0; w_valid = 0;
    r_busy = int'(busy);
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    ntests++;
    if ({busy, done, w_ready, weight_en, in_ready, out_valid} !== 6'b0 || left_en !== '0 ||
        right_en !== '0 || o_fmap !== '0 || out_idx !== '0) begin
      nfail++;
      $display("FAIL reset_state: ctl=%b left=%b right=%b idx=%0d, required all 0",
               {busy, done, w_ready, weight_en, in_ready, out_valid}, left_en, right_en, out_idx);
    end
    rst_n = 1;
    tick();
    ntests++;
    if (busy !== 1'b0 || w_ready !== 1'b0) begin
      nfail++;
      $display("FAIL idle_after_reset: busy=%b w_ready=%b required 0 0", busy, w_ready);
    end
  endtask

  task automatic test_single();
    do_job(1, 32'h1, 1, 0);
    ntests++;
    if (r_wen != 1) begin nfail++; $display("FAIL single_weight_en: pulses=%0d required 1", r_wen); end
    ntests++;
    if (r_ov != 1) begin nfail++; $display("FAIL single_ov_count: got %0d required 1", r_ov); end
    ntests++;
    if (first_ov - first_acc != 10) begin
      nfail++; $display("FAIL single_latency: got %0d required 10", first_ov - first_acc);
    end
    ntests++;
    if (r_done != 1 || done_cyc - last_ov < 1) begin
      nfail++; $display("FAIL single_done: pulses=%0d gap=%0d required 1 and >=1", r_done, done_cyc - last_ov);
    end
    ntests++;
    if (r_busy != 0) begin nfail++; $display("FAIL single_busy_end: got %0d required 0", r_busy); end
  endtask

  task automatic test_back_to_back();
    do_job(5, 32'hFFFF_FFFF, 32, 1);
    ntests++;
    if (r_ov != 5 || last_ov - first_ov != 4) begin
      nfail++; $display("FAIL b2b_ov: count=%0d span=%0d required 5 and 4", r_ov, last_ov - first_ov);
    end
    ntests++;
    if (r_done != 1 || r_wen != 1) begin
      nfail++; $display("FAIL b2b_done_wen: done=%0d wen=%0d required 1 1", r_done, r_wen);
    end
  endtask

  task automatic test_gaps();
    do_job(3, 32'b11001, 5, 1);
    ntests++;
    if (ov_bits[4:0] !== 5'b11001 || r_ov != 3) begin
      nfail++; $display("FAIL gaps_pattern: got %b count=%0d required 11001 3", ov_bits[4:0], r_ov);
    end
    ntests++;
    if (first_ov - first_acc != 10) begin
      nfail++; $display("FAIL gaps_latency: got %0d required 10", first_ov - first_acc);
    end
  endtask

  task automatic test_zero();
    do_job(0, 32'h0, 0, 0);
    ntests++;
    if (r_done != 1 || done_cyc - start_cyc != 1) begin
      nfail++; $display("FAIL zero_done: pulses=%0d delay=%0d required 1 1", r_done, done_cyc - start_cyc);
    end
    ntests++;
    if (r_wen + r_wr + r_ir + r_ov + r_bsyseen != 0) begin
      nfail++; $display("FAIL zero_quiet: wen=%0d wr=%0d ir=%0d ov=%0d busy=%0d required all 0",
                        r_wen, r_wr, r_ir, r_ov, r_bsyseen);
    end
  endtask

  task automatic test_reset_mid();
    int nacc, bad;
    bit wsent;
    nacc = 0; wsent = 0; bad = 0;
    job_idx = 0; num_vec = CW'(20); start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 60 && nacc < 12; i++) begin
      w_valid = w_ready && !wsent;
      if (w_valid) wsent = 1;
      in_valid = in_ready;
      if (in_ready) begin
        nacc++;
        for (int k = 0; k < NPE; k++) in_fmap[k*DW +: DW] = $urandom;
      end
      tick();
    end
    in_valid = 0; w_valid = 0;
    #1 rst_n = 0;
    #1;
    ntests++;
    if ({busy, done, w_ready, weight_en, in_ready, out_valid} !== 6'b0 || left_en !== '0 ||
        right_en !== '0 || o_fmap !== '0 || out_idx !== '0) begin
      nfail++;
      $display("FAIL async_reset: ctl=%b left=%b right=%b idx=%0d, required all 0",
               {busy, done, w_ready, weight_en, in_ready, out_valid}, left_en, right_en, out_idx);
    end
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || out_valid || done) bad++;
    end
    ntests++;
    if (bad != 0) begin nfail++; $display("FAIL post_reset_quiet: %0d active cycles required 0", bad); end
    do_job(1, 32'h1, 1, 1);
    ntests++;
    if (r_wen != 1 || r_ov != 1 || r_done != 1) begin
      nfail++; $display("FAIL reload_after_reset: wen=%0d ov=%0d done=%0d required 1 1 1", r_wen, r_ov, r_done);
    end
  endtask

  task automatic test_lat2();
    int c2, fl, fr, fo, nd, nw, nov, idx_at_ov;
    bit wsent, ssent, sent;
    logic [DW-1:0] w8, w8_seen;
    c2 = -1; fl = -1; fr = -1; fo = -1; nd = 0; nw = 0; nov = 0; idx_at_ov = -1;
    wsent = 0; ssent = 0; sent = 0; w8 = $urandom; w8_seen = '0;
    num_vec2 = CW'(1); start2 = 1;
    tick();
    start2 = 0;
    for (int i = 0; i < 80; i++) begin
      if (left_en2[8] && fl < 0) begin fl = cyc; w8_seen = o_fmap2[8*DW +: DW]; end
      if (right_en2[8] && fr < 0) fr = cyc;
      if (out_valid2) begin nov++; if (fo < 0) begin fo = cyc; idx_at_ov = int'(out_idx2); end end
      if (done2) nd++;
      if (weight_en2) nw++;
      w_valid2 = w_ready2 && !wsent;
      if (w_valid2) wsent = 1;
      start2 = 0;
      if (busy2 && !ssent) begin start2 = 1; num_vec2 = '0; ssent = 1; end
      in_valid2 = 0;
      if (in_ready2 && !sent) begin
        in_valid2 = 1; sent = 1; c2 = cyc;
        for (int k = 0; k < NPE; k++) in_fmap2[k*DW +: DW] = (k == 8) ? w8 : $urandom;
      end
      tick();
    end
    ntests++;
    if (c2 < 0 || fl != c2 + 17 || fr != c2 + 18) begin
      nfail++; $display("FAIL lat2_pe8_strobes: left at +%0d right at +%0d required +17 +18", fl - c2, fr - c2);
    end
    ntests++;
    if (fo != c2 + 19 || nov != 1 || idx_at_ov != 0) begin
      nfail++; $display("FAIL lat2_out_valid: at +%0d count=%0d idx=%0d required +19 1 0", fo - c2, nov, idx_at_ov);
    end
    ntests++;
    if (w8_seen !== w8) begin
      nfail++; $display("FAIL lat2_fmap_word8: got %h required %h", w8_seen, w8);
    end
    ntests++;
    if (nd != 1 || nw != 1) begin
      nfail++; $display("FAIL lat2_start_while_busy: done=%0d wen=%0d required 1 1", nd, nw);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps();
    test_zero();
    test_reset_mid();
    test_lat2();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/mpe_col_ctrl.md
Name: mpe_col_ctrl

Overview:
- Sequencer for one 9x1 PE_fpu column: loads the column weights once, then streams feature-map vectors into the column.
- Generates the per-PE skewed i_left_en / i_right_en strobes and skews the fmap data to match the psum ripple down the column.
- Flags each psum_t_down result as valid; sits between the column's input buffer and the MPE instance.

Parameters:
- DATA_WIDTH, 32, fmap word width
- NUMBER_PE, 9, PEs in the column
- PE_LATENCY, 1, cycles from a PE's i_left_en to its psum_t_down update (>=1)
- CNT_W, 16, width of the vector counters

Ports:
- i_clk  in  1  clock
- i_rest_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job start pulse
- num_vec  in  CNT_W  vectors in the job, sampled on accepted start
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- w_valid  in  1  weight words on the column weight bus are valid
- w_ready  out  1  controller is waiting for weights
- weight_en  out  1  weight-load strobe to all PEs
- in_valid  in  1  fmap vector valid
- in_ready  out  1  controller accepts a vector
- in_fmap  in  NUMBER_PE*DATA_WIDTH  vector; word k is bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_left_en  out  NUMBER_PE  per-PE fmap capture strobe
- i_right_en  out  NUMBER_PE  per-PE fmap forward strobe
- o_fmap  out  NUMBER_PE*DATA_WIDTH  skewed fmap words to the PE i_fmap_f_left ports
- out_valid  out  1  psum_t_down holds a finished result this cycle
- out_idx  out  CNT_W  vector index of the current result

Behaviour:
- Reset is asynchronous and active-low. All outputs and state clear to 0; FSM goes to IDLE; skew lines are emptied.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - start with num_vec!=0: latch num_vec, go to LOAD_W.
  - start with num_vec==0: done pulses the next cycle; stay in IDLE.
  - busy is 0 only in IDLE.
- LOAD_W:
  - w_ready=1.
  - On w_valid: weight_en is high for exactly one cycle (the cycle after the handshake), then go to STREAM.
- STREAM:
  - in_ready=1 whenever the issued count is less than num_vec. There is no other back-pressure, so the column never stalls.
  - Each accepted vector (in_valid&in_ready) injects a token plus the 9 words into the skew line, and the issued count increments.
  - When the issued count reaches num_vec, go to DRAIN; in_ready drops the same cycle the last vector is accepted.
- Enable timing: let T be the cycle after acceptance.
  - i_left_en[k] is high in cycle T + k*PE_LATENCY.
  - o_fmap word k holds in_fmap word k in that same cycle and holds its value otherwise.
  - i_right_en[k] = i_left_en[k] delayed by 1 cycle.
  - out_valid is high in cycle T + NUMBER_PE*PE_LATENCY. out_idx = vector ordinal (0-based) and increments after each out_valid.
- Back-to-back accepts produce back-to-back out_valid with no bubbles; gaps in in_valid are preserved exactly.
- DRAIN: wait until out_idx has counted num_vec results, then go to DONE.
- DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE. done and the last out_valid are never in the same cycle; done comes at least 1 cycle later.
- start while busy is ignored. in_valid outside STREAM is ignored; in_ready=0 there.
- Counters are CNT_W bits, unsigned, with no wrap: num_vec up to 2^CNT_W-1 is legal.
- Reset mid-job aborts immediately. No partial out_valid or done is produced, and weights must be reloaded.

Decomposition:
- Package mpe_pkg holds:
  - the FSM state enum (ctrl_state_t)
  - the localparams SKEW_DEPTH = NUMBER_PE*PE_LATENCY and TOTAL_LAT = NUMBER_PE*PE_LATENCY
- One sub-module, mpe_skew_line: a valid-plus-data delay line with per-tap outputs at multiples of PE_LATENCY.
  - Instantiated once for the token/valid bit.
  - Data taps: word k is delayed by k*PE_LATENCY cycles.
- FSM and counters stay in mpe_col_ctrl.

Test Plan:
- Reset: hold i_rest_n=0 mid-STREAM → all outputs 0 asynchronously; after release, busy=0 and no out_valid for 20 cycles.
- Single vector, PE_LATENCY=1:
  - Stimulus: start, num_vec=1, w_valid at cycle 2, in_fmap words 1..9.
  - Response: weight_en one pulse; i_left_en[k] at T+k with o_fmap word k = k+1; out_valid at T+9 with out_idx=0; done 1+ cycle later.
- Stream of 5 back-to-back vectors → out_valid high for exactly 5 consecutive cycles, out_idx 0..4, single done pulse.
- in_valid gaps (pattern 1,0,0,1,1) with num_vec=3 → out_valid pattern 1,0,0,1,1 delayed by exactly 9 cycles.
- num_vec=0 start → done pulse next cycle; weight_en, w_ready and in_ready never asserted.
- PE_LATENCY=2:
  - Stimulus: second start pulse sent while busy.
  - Response: the second start is ignored; i_left_en[8] at T+16, i_right_en[8] at T+17, out_valid at T+18.
